// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t. Entries shift toward slot 0 on pop, so the
// head is always a flop output. Empty slots are held at zero so an empty
// queue presents an all-zero head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  fetch_entry_t     ent_q [DEPTH];
  fetch_entry_t     ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] base;
  logic             valid_q, valid_d;
  logic             do_pop, do_push;

  // Next queue contents: flush wins, otherwise shift out the head then append.
  always_comb begin
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    base    = cnt_q;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (flush_i) begin
      ent_d = '{default: '0};
      cnt_d = '0;
    end else begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q < CNT_W'(DEPTH)) || do_pop);
      if (do_pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          ent_d[IDX_W'(i)] = ent_q[IDX_W'(i + 1)];
        end
        ent_d[IDX_W'(DEPTH - 1)] = '0;
      end
      base = cnt_q - CNT_W'(do_pop);
      if (do_push) begin
        ent_d[base[IDX_W-1:0]] = push_data_i;
      end
      cnt_d = base + CNT_W'(do_push);
    end
    valid_d = (cnt_d != '0);
  end

  // Queue storage, occupancy and registered head-valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '{default: '0};
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = ent_q[0];
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures {pc, inst} from a
// combinational instruction memory into a prefetch queue and hands the head to
// decode over valid/ready. Redirects flush the queue; a misaligned redirect
// target parks the block in FAULT until an aligned redirect or reset.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned IMEM_BYTES  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic              if_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  // Elaboration-time sanity of the configuration.
  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_ctrl: QUEUE_DEPTH must be a power of two >= 2");
  end
  if ((IMEM_BYTES < 4) || ((IMEM_BYTES & (IMEM_BYTES - 1)) != 0)) begin : g_bad_imem
    $error("fetch_ctrl: IMEM_BYTES must be a power of two >= 4 so fetch wraps cleanly");
  end

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             fault_q, fault_d;
  logic             push, pop;
  logic             q_valid;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     q_in;

  assign q_in = '{pc: fetch_pc_q, inst: imem_inst};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push),
    .push_data_i (q_in),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (q_head),
    .valid_o     (q_valid),
    .count_o     (q_count)
  );

  // Next state, fetch PC and queue control; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      RUN: begin
        pop  = q_valid && if_ready && !redirect_valid;
        push = !redirect_valid && ((q_count < CNT_W'(QUEUE_DEPTH)) || pop);
        if (push) begin
          fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      state_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
    end
    fault_d = (state_d == FAULT);
  end

  // State, fetch PC and fault flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  // In FAULT the fetch PC holds the faulting target, so it drives memory in both states.
  assign imem_addr = fetch_pc_q;
  assign if_valid  = q_valid;
  assign if_inst   = q_head.inst;
  assign if_pc     = q_head.pc;
  assign if_fault  = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Delivered-instruction and decode-stall counters, wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (q_valid && !if_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the byte-addressed, big-endian 4 KB instruction memory.
- Owns the fetch PC and drives the memory address.
- Memory returns the 32-bit word combinationally from the address in the same cycle. The block captures {pc, inst} pairs into a small prefetch queue.
- Hands instructions to decode over a valid/ready handshake. Handles branch/jump redirects, flushes and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- QUEUE_DEPTH, 2, prefetch queue entries (power of two, >=2).
- IMEM_BYTES, 4096, instruction memory size; used only for the wrap check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory.
- imem_inst  in  32  instruction word at imem_addr, valid same cycle.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch target.
- if_valid  out  1  queue head holds a valid instruction.
- if_ready  in  1  decode accepts the head this cycle.
- if_inst  out  32  head instruction.
- if_pc  out  32  head PC.
- if_fault  out  1  misaligned redirect target; fetch halted.

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - fetch_pc=RESET_PC, queue empty, state=RUN.
  - if_valid=0, if_inst=0, if_pc=0, if_fault=0.
  - imem_addr=RESET_PC.
- States: RUN, FAULT.
- RUN:
  - imem_addr = fetch_pc.
  - push = !redirect_valid && (count<QUEUE_DEPTH || pop). pop = if_valid && if_ready.
  - On push: enqueue {fetch_pc, imem_inst}; fetch_pc <= fetch_pc+4, modulo 2^32.
- Queue: FIFO, head registered.
  - if_valid = (count!=0); if_inst/if_pc show the head entry; they are 0 when empty.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
- Latency:
  - First instruction after reset or redirect appears on if_valid exactly 1 cycle later.
  - Steady state with if_ready=1: one instruction per cycle.
- Redirect has priority over push and pop. On redirect_valid=1:
  - Queue flushed next edge; if_valid=0 next cycle.
  - The current head is NOT consumed even if if_ready=1.
  - fetch_pc <= redirect_pc.
  - If redirect_pc[1:0]!=0: go to FAULT instead.
- FAULT:
  - No pushes; queue empty; if_valid=0; if_fault=1; imem_addr holds the faulting redirect_pc.
  - Exit only on an aligned redirect (back to RUN, if_fault=0 next cycle) or on reset.
  - A misaligned redirect while in FAULT stays in FAULT and updates imem_addr.
- Wrap: fetch_pc increments past IMEM_BYTES-4 freely. The memory decodes low address bits, so instructions repeat from offset 0. No fault is raised.
- if_ready with if_valid=0 is ignored.
- Decode backpressure (if_ready=0) never drops entries. Fetch stops when the queue is full and no pop occurs.
- Reset mid-operation: immediate return to reset values regardless of state or queue contents.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32b) and perf_stall (32b), both reset to 0 and wrapping modulo 2^32.
  - perf_fetched increments on every pop.
  - perf_stall increments each cycle with if_valid=1 and if_ready=0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg holds:
  - INST_W=32, PC_STEP=4, INST_NOP=32'h0000_0013.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0]}.
  - Enum fetch_state_t {RUN, FAULT}.
- One natural sub-module: fetch_queue. A parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, head and an asynchronous reset.

Test Plan:
- Reset, memory words 0x00000013 at 0x0 and 0x00100093 at 0x4, if_ready=1 -> cycle 1: if_pc=0x0, if_inst=0x00000013; cycle 2: if_pc=0x4, if_inst=0x00100093; one instruction per cycle.
- Hold if_ready=0 for 5 cycles -> count saturates at 2, imem_addr stops at 0x8; release -> if_pc sequence 0x0, 0x4, 0x8 with no gaps or losses.
- Redirect redirect_pc=0x100 while queue full and if_ready=1 -> next cycle if_valid=0; following cycle if_pc=0x100; old entries never delivered.
- Redirect to 0x102 -> if_fault=1, if_valid=0 indefinitely; then redirect to 0x200 -> if_fault=0, next instruction if_pc=0x200.
- Assert reset asynchronously mid-stream with queue full -> if_valid=0, imem_addr=RESET_PC immediately, without waiting for a clock edge.
- RESET_PC=0xFF8, if_ready=1 -> if_pc sequence 0xFF8, 0xFFC, 0x1000; the word at 0x1000 equals the word at 0x0.
